// File: rtl/aes_reg_sequencer.sv
// aes_reg_sequencer: replays queued register-bus commands (write / read /
// checked read) onto a cs/we/address/write_data/read_data core interface.
// Read results are returned through a first-word-fall-through response FIFO.
// A read is only issued when its response slot is guaranteed.
module aes_reg_sequencer #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int CMD_DEPTH = 8,
   parameter int RSP_DEPTH = 4,
   parameter int READ_LAT  = 1,
   parameter int CNT_W     = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic                           cmd_we,
   input  logic                           cmd_check,
   input  logic [ADDR_W-1:0]              cmd_addr,
   input  logic [DATA_W-1:0]              cmd_wdata,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [ADDR_W-1:0]              rsp_addr,
   output logic [DATA_W-1:0]              rsp_data,
   output logic                           rsp_mismatch,
   output logic                           cs,
   output logic                           we,
   output logic [ADDR_W-1:0]              address,
   output logic [DATA_W-1:0]              write_data,
   input  logic [DATA_W-1:0]              read_data,
   output logic                           busy,
   output logic [$clog2(CMD_DEPTH):0]     cmd_count,
   output logic [CNT_W-1:0]               mismatch_count
);

   localparam int CP    = $clog2(CMD_DEPTH);
   localparam int RP    = $clog2(RSP_DEPTH);
   localparam int CE_W  = 2 + ADDR_W + DATA_W;
   localparam int RE_W  = ADDR_W + DATA_W + 1;
   localparam logic [CP:0] CMD_FULL = CMD_DEPTH[CP:0];
   localparam logic [RP:0] RSP_FULL = RSP_DEPTH[RP:0];
   localparam logic [2:0]  LAT_LAST = READ_LAT[2:0];

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WRITE   = 2'd1,
      ST_READ    = 2'd2,
      ST_CAPTURE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CE_W-1:0]     cmd_mem_q [CMD_DEPTH];
   logic [RE_W-1:0]     rsp_mem_q [RSP_DEPTH];
   logic [CP:0]         cmd_wr_q, cmd_rd_q;
   logic [RP:0]         rsp_wr_q, rsp_rd_q;
   logic                cs_q, cs_d, we_q, we_d;
   logic [ADDR_W-1:0]   address_q, address_d;
   logic [DATA_W-1:0]   write_data_q, write_data_d;
   logic                check_q, check_d;
   logic [DATA_W-1:0]   exp_q, exp_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [2:0]          lat_q, lat_d;
   logic [CNT_W-1:0]    mcount_q, mcount_d;

   logic                cmd_empty_s, cmd_push_s, cmd_pop_s;
   logic [CP:0]         cmd_count_s;
   logic [RP:0]         rsp_count_s;
   logic                rsp_empty_s, rsp_push_s, rsp_pop_s, rsp_space_s;
   logic                mismatch_s;
   logic [CE_W-1:0]     head_s;
   logic                head_we_s, head_check_s;
   logic [ADDR_W-1:0]   head_addr_s;
   logic [DATA_W-1:0]   head_wdata_s;
   logic [RE_W-1:0]     rsp_head_s;

   // FIFO status, head decode and output wiring (all from registers)
   always_comb begin
      cmd_count_s  = cmd_wr_q - cmd_rd_q;
      cmd_empty_s  = (cmd_wr_q == cmd_rd_q);
      cmd_ready    = (cmd_count_s != CMD_FULL);
      cmd_push_s   = cmd_valid && cmd_ready;
      head_s       = cmd_mem_q[cmd_rd_q[CP-1:0]];
      {head_we_s, head_check_s, head_addr_s, head_wdata_s} = head_s;
      rsp_count_s  = rsp_wr_q - rsp_rd_q;
      rsp_empty_s  = (rsp_wr_q == rsp_rd_q);
      rsp_valid    = !rsp_empty_s;
      rsp_pop_s    = rsp_valid && rsp_ready;
      rsp_space_s  = (rsp_count_s != RSP_FULL) || rsp_pop_s;
      rsp_head_s   = rsp_mem_q[rsp_rd_q[RP-1:0]];
      {rsp_addr, rsp_data, rsp_mismatch} = rsp_head_s;
      cs             = cs_q;
      we             = we_q;
      address        = address_q;
      write_data     = write_data_q;
      cmd_count      = cmd_count_s;
      mismatch_count = mcount_q;
      busy           = (state_q != ST_IDLE) || !cmd_empty_s;
   end

   // Next-state and bus-drive logic of the command sequencer
   always_comb begin
      state_d      = state_q;
      cs_d         = 1'b0;
      we_d         = 1'b0;
      address_d    = address_q;
      write_data_d = write_data_q;
      check_d      = check_q;
      exp_d        = exp_q;
      rdata_d      = rdata_q;
      lat_d        = lat_q;
      mcount_d     = mcount_q;
      cmd_pop_s    = 1'b0;
      rsp_push_s   = 1'b0;
      mismatch_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!cmd_empty_s && head_we_s) begin
               cmd_pop_s    = 1'b1;
               state_d      = ST_WRITE;
               cs_d         = 1'b1;
               we_d         = 1'b1;
               address_d    = head_addr_s;
               write_data_d = head_wdata_s;
            end else if (!cmd_empty_s && rsp_space_s) begin
               cmd_pop_s = 1'b1;
               state_d   = ST_READ;
               cs_d      = 1'b1;
               address_d = head_addr_s;
               check_d   = head_check_s;
               exp_d     = head_wdata_s;
               lat_d     = 3'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            state_d = ST_IDLE;
         end
         ST_READ: begin
            if (lat_q == LAT_LAST) begin
               rdata_d = read_data;
               state_d = ST_CAPTURE;
            end else begin
               cs_d  = 1'b1;
               lat_d = lat_q + 3'd1;
            end
         end
         ST_CAPTURE: begin
            rsp_push_s = 1'b1;
            mismatch_s = check_q && (rdata_q != exp_q);
            if (mismatch_s && (mcount_q != {CNT_W{1'b1}})) begin
               mcount_d = mcount_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               mcount_d = mcount_q;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control registers, FIFO pointers and bus outputs with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cmd_wr_q     <= '0;
         cmd_rd_q     <= '0;
         rsp_wr_q     <= '0;
         rsp_rd_q     <= '0;
         cs_q         <= 1'b0;
         we_q         <= 1'b0;
         address_q    <= '0;
         write_data_q <= '0;
         check_q      <= 1'b0;
         exp_q        <= '0;
         rdata_q      <= '0;
         lat_q        <= 3'd0;
         mcount_q     <= '0;
      end else begin
         state_q      <= state_d;
         cmd_wr_q     <= cmd_wr_q + {{CP{1'b0}}, cmd_push_s};
         cmd_rd_q     <= cmd_rd_q + {{CP{1'b0}}, cmd_pop_s};
         rsp_wr_q     <= rsp_wr_q + {{RP{1'b0}}, rsp_push_s};
         rsp_rd_q     <= rsp_rd_q + {{RP{1'b0}}, rsp_pop_s};
         cs_q         <= cs_d;
         we_q         <= we_d;
         address_q    <= address_d;
         write_data_q <= write_data_d;
         check_q      <= check_d;
         exp_q        <= exp_d;
         rdata_q      <= rdata_d;
         lat_q        <= lat_d;
         mcount_q     <= mcount_d;
      end
   end

   // FIFO storage arrays; contents are don't-care while their pointers say empty
   always_ff @(posedge clk) begin
      if (cmd_push_s) begin
         cmd_mem_q[cmd_wr_q[CP-1:0]] <= {cmd_we, cmd_check, cmd_addr, cmd_wdata};
      end
      if (rsp_push_s) begin
         rsp_mem_q[rsp_wr_q[RP-1:0]] <= {address_q, rdata_q, mismatch_s};
      end
   end

endmodule
